// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, write-back port, issue port and scoreboard status.
// The master is the pipeline side; the slave is the register file.
interface reg_file_sb_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned READ_PORTS = 2
);
  logic [READ_PORTS*ADDR_W-1:0] rd_id;
  logic [READ_PORTS*WIDTH-1:0]  rd_value;
  logic [READ_PORTS-1:0]        rd_busy;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_id;
  logic [WIDTH-1:0]             wr_value;
  logic                         issue_en;
  logic [ADDR_W-1:0]            issue_id;
  logic                         issue_ready;
  logic                         sb_error;

  modport master (
    output rd_id, wr_en, wr_id, wr_value, issue_en, issue_id,
    input  rd_value, rd_busy, issue_ready, sb_error
  );

  modport slave (
    input  rd_id, wr_en, wr_id, wr_value, issue_en, issue_id,
    output rd_value, rd_busy, issue_ready, sb_error
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, one write port and a per-register
// in-flight write scoreboard. Define REG_FILE_BYPASS_EN for write-through read bypass.
module reg_file_sb #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned CNT_W      = 2
) (
  input logic         clock,
  input logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic              sb_error_q;
  logic [ADDR_W-1:0] rid [READ_PORTS];

  logic wr_act, issue_act, issue_acc, issue_ovf, wr_unf;

  function automatic logic is_zero(input logic [ADDR_W-1:0] id);
    return (ZERO_REG != 0) && (id == '0);
  endfunction

  assign wr_act    = bus.wr_en && !is_zero(bus.wr_id);
  assign issue_act = bus.issue_en && !is_zero(bus.issue_id);

  // Readiness looks only at stored counts, never at the same-cycle write-back.
  assign bus.issue_ready = (cnt_q[bus.issue_id] != CntMax);
  assign issue_acc = issue_act && bus.issue_ready;
  assign issue_ovf = issue_act && !bus.issue_ready;
  assign wr_unf    = wr_act && (cnt_q[bus.wr_id] == '0) &&
                     !(issue_acc && (bus.issue_id == bus.wr_id));
  assign bus.sb_error = sb_error_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic inc, dec;
      inc = issue_acc && (bus.issue_id == ADDR_W'(i));
      dec = wr_act && (bus.wr_id == ADDR_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_error_q <= 1'b0;
    end else begin
      if (wr_act) begin
        regs_q[bus.wr_id] <= bus.wr_value;
      end
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (wr_unf || issue_ovf) begin
        sb_error_q <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rid
    assign rid[p] = bus.rd_id[p*ADDR_W +: ADDR_W];
  end

  always_comb begin
    bus.rd_value = '0;
    bus.rd_busy  = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (!is_zero(rid[p])) begin
`ifdef REG_FILE_BYPASS_EN
        if (wr_act && (bus.wr_id == rid[p])) begin
          bus.rd_value[p*WIDTH +: WIDTH] = bus.wr_value;
          // The bypassed write retires one pending count already this cycle.
          bus.rd_busy[p] = (cnt_q[rid[p]] > CNT_W'(1));
        end else begin
          bus.rd_value[p*WIDTH +: WIDTH] = regs_q[rid[p]];
          bus.rd_busy[p] = (cnt_q[rid[p]] != '0);
        end
`else
        bus.rd_value[p*WIDTH +: WIDTH] = regs_q[rid[p]];
        bus.rd_busy[p] = (cnt_q[rid[p]] != '0);
`endif
      end
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with three read ports; expectations follow the
// REG_FILE_BYPASS_EN setting of the build.
module tb_reg_file_sb;
  localparam int unsigned W  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RP = 3;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  reg_file_sb_if #(.WIDTH(W), .ADDR_W(AW), .READ_PORTS(RP)) bus ();

  reg_file_sb #(
    .WIDTH(W), .ADDR_W(AW), .READ_PORTS(RP), .ZERO_REG(1), .CNT_W(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.wr_id    = '0;
    bus.wr_value = '0;
    bus.issue_en = 1'b0;
    bus.issue_id = '0;
  endtask

  task automatic read_all(input logic [AW-1:0] id);
    bus.rd_id = {RP{id}};
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] id);
    idle();
    bus.issue_en = 1'b1;
    bus.issue_id = id;
    step();
    idle();
  endtask

  task automatic write(input logic [AW-1:0] id, input logic [W-1:0] val);
    idle();
    bus.wr_en    = 1'b1;
    bus.wr_id    = id;
    bus.wr_value = val;
    step();
    idle();
  endtask

  task automatic test_reset();
    read_all(5'd5);
    for (int p = 0; p < RP; p++) begin
      vectors++;
      if (bus.rd_value[p*W +: W] !== 32'h0) begin
        errors++;
        $display("FAIL init_value p%0d: got %h want 0", p, bus.rd_value[p*W +: W]);
      end
    end
    vectors++;
    if (bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready: got %b want 1", bus.issue_ready);
    end
    write(5'd5, 32'h1234);
    read_all(5'd5);
    vectors++;
    if (bus.rd_value[W-1:0] !== 32'h1234) begin
      errors++;
      $display("FAIL write_r5: got %h want 00001234", bus.rd_value[W-1:0]);
    end
    bus.wr_en = 1'b1; bus.wr_id = 5'd5; bus.wr_value = 32'hDEAD;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    read_all(5'd5);
    vectors++;
    if (bus.rd_value[W-1:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_r5: got %h want 0", bus.rd_value[W-1:0]);
    end
    vectors++;
    if (bus.rd_busy !== 3'b000 || bus.issue_ready !== 1'b1 || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ready=%b err=%b want 000/1/0",
               bus.rd_busy, bus.issue_ready, bus.sb_error);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    bus.wr_en = 1'b1; bus.wr_id = 5'd0; bus.wr_value = 32'hFFFF_FFFF;
    bus.issue_en = 1'b1; bus.issue_id = 5'd0;
    read_all(5'd0);
    vectors++;
    if (bus.rd_value !== '0 || bus.rd_busy !== 3'b000) begin
      errors++;
      $display("FAIL zero_same_cycle: val=%h busy=%b want 0/000", bus.rd_value, bus.rd_busy);
    end
    step();
    idle();
    read_all(5'd0);
    vectors++;
    if (bus.rd_value !== '0 || bus.rd_busy !== 3'b000 || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: val=%h busy=%b err=%b want 0/000/0",
               bus.rd_value, bus.rd_busy, bus.sb_error);
    end
  endtask

  task automatic test_scoreboard();
    logic [2:0] exp_busy [3];
    exp_busy = '{3'b111, 3'b111, 3'b000};
    issue(5'd7);
    issue(5'd7);
    read_all(5'd7);
    vectors++;
    if (bus.rd_busy !== exp_busy[0]) begin
      errors++;
      $display("FAIL sb_after_issue: got %b want %b", bus.rd_busy, exp_busy[0]);
    end
    write(5'd7, 32'hA);
    read_all(5'd7);
    vectors++;
    if (bus.rd_busy !== exp_busy[1]) begin
      errors++;
      $display("FAIL sb_after_wr_a: got %b want %b", bus.rd_busy, exp_busy[1]);
    end
    write(5'd7, 32'hB);
    read_all(5'd7);
    vectors++;
    if (bus.rd_busy !== exp_busy[2]) begin
      errors++;
      $display("FAIL sb_after_wr_b: got %b want %b", bus.rd_busy, exp_busy[2]);
    end
    vectors++;
    if (bus.rd_value[W-1:0] !== 32'hB || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL sb_value: val=%h err=%b want 0000000b/0", bus.rd_value[W-1:0], bus.sb_error);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) issue(5'd3);
    bus.issue_id = 5'd3;
    #1;
    vectors++;
    if (bus.issue_ready !== 1'b0 || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: ready=%b err=%b want 0/0", bus.issue_ready, bus.sb_error);
    end
    // A pending write-back must not make the full counter look ready.
    bus.wr_en = 1'b1; bus.wr_id = 5'd3;
    #1;
    vectors++;
    if (bus.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready_vs_wr: got %b want 0", bus.issue_ready);
    end
    issue(5'd3);
    read_all(5'd3);
    vectors++;
    if (bus.sb_error !== 1'b1 || bus.rd_busy !== 3'b111) begin
      errors++;
      $display("FAIL ovf_4th: err=%b busy=%b want 1/111", bus.sb_error, bus.rd_busy);
    end
    write(5'd3, 32'h33);
    bus.issue_id = 5'd3;
    #1;
    vectors++;
    if (bus.sb_error !== 1'b1 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after_wr: err=%b ready=%b want 1/1", bus.sb_error, bus.issue_ready);
    end
    write(5'd3, 32'h34);
    read_all(5'd3);
    vectors++;
    if (bus.rd_busy !== 3'b111) begin
      errors++;
      $display("FAIL ovf_cnt1: busy=%b want 111", bus.rd_busy);
    end
    write(5'd3, 32'h35);
    read_all(5'd3);
    vectors++;
    if (bus.rd_busy !== 3'b000) begin
      errors++;
      $display("FAIL ovf_cnt0: busy=%b want 000", bus.rd_busy);
    end
    do_reset();
    vectors++;
    if (bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL ovf_err_clear: got %b want 0", bus.sb_error);
    end
  endtask

  task automatic test_same_cycle();
    issue(5'd9);
    bus.issue_en = 1'b1; bus.issue_id = 5'd9;
    bus.wr_en = 1'b1; bus.wr_id = 5'd9; bus.wr_value = 32'h99;
    step();
    idle();
    read_all(5'd9);
    vectors++;
    if (bus.rd_busy !== 3'b111 || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle: busy=%b err=%b want 111/0", bus.rd_busy, bus.sb_error);
    end
    write(5'd9, 32'h9A);
    read_all(5'd9);
    vectors++;
    if (bus.rd_busy !== 3'b000 || bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_drain: busy=%b err=%b want 000/0", bus.rd_busy, bus.sb_error);
    end
    write(5'd4, 32'h44);
    read_all(5'd4);
    vectors++;
    if (bus.rd_value[W-1:0] !== 32'h44 || bus.sb_error !== 1'b1 || bus.rd_busy !== 3'b000) begin
      errors++;
      $display("FAIL underflow: val=%h err=%b busy=%b want 00000044/1/000",
               bus.rd_value[W-1:0], bus.sb_error, bus.rd_busy);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp_val;
    logic         exp_busy;
    do_reset();
    // Issue and write together: preloads r12 without disturbing the count.
    bus.issue_en = 1'b1; bus.issue_id = 5'd12;
    bus.wr_en = 1'b1; bus.wr_id = 5'd12; bus.wr_value = 32'h11;
    step();
    idle();
    issue(5'd12);
    bus.wr_en = 1'b1; bus.wr_id = 5'd12; bus.wr_value = 32'h55;
    read_all(5'd12);
`ifdef REG_FILE_BYPASS_EN
    exp_val = 32'h55; exp_busy = 1'b0;
`else
    exp_val = 32'h11; exp_busy = 1'b1;
`endif
    for (int p = 0; p < RP; p++) begin
      vectors++;
      if (bus.rd_value[p*W +: W] !== exp_val || bus.rd_busy[p] !== exp_busy) begin
        errors++;
        $display("FAIL bypass_cycle p%0d: val=%h busy=%b want %h/%b",
                 p, bus.rd_value[p*W +: W], bus.rd_busy[p], exp_val, exp_busy);
      end
    end
    step();
    idle();
    read_all(5'd12);
    for (int p = 0; p < RP; p++) begin
      vectors++;
      if (bus.rd_value[p*W +: W] !== 32'h55 || bus.rd_busy[p] !== 1'b0) begin
        errors++;
        $display("FAIL bypass_next p%0d: val=%h busy=%b want 00000055/0",
                 p, bus.rd_value[p*W +: W], bus.rd_busy[p]);
      end
    end
    vectors++;
    if (bus.sb_error !== 1'b0) begin
      errors++;
      $display("FAIL bypass_err: got %b want 0", bus.sb_error);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    bus.rd_id = '0;
    idle();
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_overflow();
    test_same_cycle();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
